// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit cell per clock, LSB first.
// Operands and mode are captured on an accepted start. The carry/borrow ripples
// through a single flop across WIDTH RUN cycles, and the result is assembled by
// shifting each new bit in at the MSB.
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add the 'ovf' output, which
// reports signed two's-complement overflow for the finished operation.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // Width of the bit counter; it only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // FSM encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    // The operand MSBs shift out during RUN, so their signs are kept aside
    // for the overflow decision made on the last bit.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
    logic             ovf_calc;
`endif

    // Single bit cell signals.
    logic bit_a;
    logic bit_b;
    logic bit_x;
    logic bit_s;
    logic carry_add;
    logic borrow_sub;
    logic c_next;

    // One full-adder / full-subtractor cell operating on the operand LSBs.
    always_comb begin
        bit_a      = a_q[0];
        bit_b      = b_q[0];
        bit_x      = bit_a ^ bit_b;
        bit_s      = bit_x ^ c_q;
        carry_add  = (bit_a & bit_b) | (c_q & bit_x);
        borrow_sub = (~bit_a & bit_b) | (c_q & ~bit_x);
        c_next     = mode_q ? borrow_sub : carry_add;
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed overflow, evaluated with the final result MSB (the last sum bit).
    always_comb begin
        if (mode_q) begin
            ovf_calc = (a_msb_q != b_msb_q) && (bit_s != a_msb_q);
        end else begin
            ovf_calc = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
        end
    end
`endif

    // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SERIAL_ADDSUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                res_d = {bit_s, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    cout_d  = c_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = ovf_calc;
`endif
                end
            end
            DONE: begin
                // start is deliberately ignored here; the next accept is from IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Overflow flag and captured operand signs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed table-driven bench for serial_addsub (WIDTH=8),
// plus hand-written sequences for ignored start, mid-operation reset and
// back-to-back operation with start held high.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int unsigned total;
    int unsigned bad;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef SERIAL_ADDSUB_OVF_EN
        .cout   (cout),
        .ovf    (ovf)
`else
        .cout   (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE and checks latency, result, flags and pulse width.
    task automatic run_op(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        chk($sformatf("busy_after_start[%0d]", idx), {31'd0, busy}, 32'd1);
        start = 1'b0;
        // scramble inputs: must not disturb the operation in flight
        a     = ~v.a;
        b     = v.a ^ v.b;
        mode  = ~v.mode;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk($sformatf("latency[%0d]", idx), n, W);
        chk($sformatf("busy_at_done[%0d]", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("result[%0d]", idx), {24'd0, result}, {24'd0, v.res});
        chk($sformatf("cout[%0d]", idx), {31'd0, cout}, {31'd0, v.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
        chk($sformatf("ovf[%0d]", idx), {31'd0, ovf}, {31'd0, v.ovf});
`endif
        @(posedge clk);
        #1;
        chk($sformatf("done_width[%0d]", idx), {31'd0, done}, 32'd0);
        chk($sformatf("result_hold[%0d]", idx), {24'd0, result}, {24'd0, v.res});
    endtask

    initial begin
        int ndone;
        int first_done;
        int last_done;
        logic prev_done;

        total = 0;
        bad   = 0;
        // mode, a, b, result, cout, ovf
        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        // reset state, with start already requested before release
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("first_op_result", {24'd0, result}, 32'h46);
        chk("first_op_dones", ndone, 1);

        for (int i = 0; i < 10; i++) run_op(vecs[i], i);

        // re-pulsed start while busy is ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ignored_start_result", {24'd0, result}, 32'h02);
        chk("ignored_start_cout", {31'd0, cout}, 32'd0);
        chk("ignored_start_dones", ndone, 1);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        // reset 4 cycles into an operation
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(vecs[0], 100);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'h10; b = 8'h20;
        ndone = 0;
        first_done = -1;
        last_done = -1;
        prev_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = i;
                else chk("b2b_spacing", i - last_done, W + 2);
                last_done = i;
                chk("b2b_result", {24'd0, result}, 32'hF0);
                chk("b2b_cout", {31'd0, cout}, 32'd1);
                if (prev_done) chk("b2b_done_width", 32'd2, 32'd1);
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("b2b_first_done", first_done, W);
        chk("b2b_count", ndone, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  WIDTH  sum or difference, LSB-first assembled.
REQ-011 cout  output  1  final carry (add) or final borrow (subtract).

Function
REQ-012 Datapath is one full-adder/full-subtractor bit cell per cycle, LSB first, with a single carry/borrow flop; no parallel WIDTH-bit adder.
REQ-013 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 at edge k loads a, b, and mode into internal registers, clears the carry/borrow flop and the bit counter, and moves to RUN; busy=1 from edge k.
REQ-015 RUN: each edge processes one bit: sum = a^b^c, carry = ab|c(a^b) (add); diff = a^b^c, borrow = ~a·b|c·~(a^b) (subtract); result bit shifted in at MSB, operands shifted right.
REQ-016 After WIDTH RUN edges (edge k+WIDTH): FSM moves to DONE, busy=0, done=1, result and cout final.
REQ-017 DONE lasts exactly one cycle; the next edge returns to IDLE and drops done to 0.
REQ-018 Latency: start edge to done high = WIDTH edges; throughput is one operation per WIDTH+2 cycles.
REQ-019 start while busy=1 or in DONE is ignored; the operation in flight and its latched operands are unaffected.
REQ-020 Changes on a, b, and mode after the start edge do not affect the operation.
REQ-021 result and cout hold their final values from done until the next accepted start; they are undefined-but-stable (shifting) during RUN and must not be used there.
REQ-022 Arithmetic is modulo 2^WIDTH; subtract uses a direct borrow chain (borrow-in 0), and cout=1 means a<b unsigned.

Reset
REQ-023 rst=1 forces, asynchronously: state=IDLE, busy=0, done=0, result=0, cout=0, counter=0, carry/borrow flop=0, operand registers=0.
REQ-024 rst asserted mid-operation aborts it; no done pulse is produced for the aborted operation.
REQ-025 The first start is accepted at the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SERIAL_ADDSUB_OVF_EN: when defined, an extra output ovf (1 bit) exists and is set at done to signed two's-complement overflow: add = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]); subtract = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]). It holds until the next accepted start and resets to 0.
REQ-027 When SERIAL_ADDSUB_OVF_EN is undefined, the ovf port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-028 Add 0x5A+0x3C -> done 8 edges after start; result=0x96, cout=0, ovf=1 (if enabled).
REQ-029 Subtract 0x10-0x20 -> result=0xF0, cout=1 (borrow), ovf=0.
REQ-030 Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0; then subtract 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
REQ-031 start with a=0x01 and b=0x01 (add), then re-pulse start with a=0xFF 3 cycles later -> second start ignored; result=0x02, exactly one done pulse.
REQ-032 rst asserted 4 cycles into an operation -> busy/done/result/cout go to 0 immediately; no done pulse; the next start completes normally.
REQ-033 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles, each done a single cycle wide.
